// File: rtl/eth_rx_dispatch.sv
// Ethernet receive dispatcher: parses the 14-byte header, filters on destination
// MAC and ethertype, and forwards the payload to one of NUM_CH channels.
module eth_rx_dispatch #(
  parameter int                   NUM_CH      = 2,
  parameter logic [16*NUM_CH-1:0] ETYPE_TABLE = {16'h0800, 16'h0806},
  parameter int                   CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [47:0]           local_mac_addr,
  input  logic                  promisc_in,
  input  logic [7:0]            axis_tdata_in,
  input  logic                  axis_tvalid_in,
  input  logic                  axis_tlast_in,
  output logic                  axis_tready_o,
  output logic [8*NUM_CH-1:0]   ch_tdata_out,
  output logic [NUM_CH-1:0]     ch_tvalid_out,
  output logic [NUM_CH-1:0]     ch_tlast_out,
  input  logic [NUM_CH-1:0]     ch_tready_in,
  output logic [47:0]           src_mac_out,
  output logic [15:0]           etype_out,
  output logic [2:0]            ch_sel_out,
  output logic [CNT_W-1:0]      frame_cnt_out,
  output logic [CNT_W-1:0]      drop_cnt_out,
  output logic [CNT_W-1:0]      runt_cnt_out,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a byte moves on a channel when valid and ready are both 1 at a
  // rising clk edge; valid never waits for ready and a held byte stays stable.
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FWD, S_DROP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [47:0]      dst_q, dst_d;
  logic [47:0]      src_q, src_d;
  logic [7:0]       ety_hi_q, ety_hi_d;
  logic [47:0]      src_out_q, src_out_d;
  logic [15:0]      etype_out_q, etype_out_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [2:0]       out_sel_q, out_sel_d;
  logic             rdy_en_q;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;

  logic        sel_rdy, ready, accept, hit, dst_ok;
  logic [2:0]  hit_idx;
  logic [15:0] hdr_etype;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The held byte is tracked by its own channel so a new header can retarget
  // ch_sel_out while the previous frame's last byte is still waiting.
  always_comb begin
    sel_rdy = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (out_sel_q == 3'(i)) sel_rdy = ch_tready_in[i];
  end

  assign hdr_etype = {ety_hi_q, axis_tdata_in};
  assign dst_ok    = promisc_in || (dst_q == local_mac_addr) || (&dst_q);

  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ETYPE_TABLE[16*i +: 16] == hdr_etype) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_comb begin
    ready = rdy_en_q;
    if (state_q == S_FWD) ready = rdy_en_q & (~out_valid_q | sel_rdy);
  end

  assign axis_tready_o = ready;
  assign accept        = axis_tvalid_in & ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dst_d       = dst_q;
    src_d       = src_q;
    ety_hi_d    = ety_hi_q;
    src_out_d   = src_out_q;
    etype_out_d = etype_out_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~sel_rdy;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    runt_cnt_d  = runt_cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        dst_d = {dst_q[39:0], axis_tdata_in};
        if (axis_tlast_in) runt_cnt_d = sat_inc(runt_cnt_q);
        else begin
          cnt_d   = 4'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: if (accept) begin
        if (cnt_q <= 4'd5)       dst_d    = {dst_q[39:0], axis_tdata_in};
        else if (cnt_q <= 4'd11) src_d    = {src_q[39:0], axis_tdata_in};
        else if (cnt_q == 4'd12) ety_hi_d = axis_tdata_in;
        cnt_d = cnt_q + 4'd1;
        if (axis_tlast_in) begin
          runt_cnt_d = sat_inc(runt_cnt_q);
          cnt_d      = 4'd0;
          state_d    = S_IDLE;
        end else if (cnt_q == 4'd13) begin
          cnt_d = 4'd0;
          if (dst_ok && hit) begin
            sel_d       = hit_idx;
            src_out_d   = src_q;
            etype_out_d = hdr_etype;
            state_d     = S_FWD;
          end else begin
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = S_DROP;
          end
        end
      end
      S_FWD: if (accept) begin
        out_data_d  = axis_tdata_in;
        out_valid_d = 1'b1;
        out_last_d  = axis_tlast_in;
        out_sel_d   = sel_q;
        if (axis_tlast_in) begin
          frame_cnt_d = sat_inc(frame_cnt_q);
          state_d     = S_IDLE;
        end
      end
      S_DROP: if (accept && axis_tlast_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      ety_hi_q    <= '0;
      src_out_q   <= '0;
      etype_out_q <= '0;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      rdy_en_q    <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      runt_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      ety_hi_q    <= ety_hi_d;
      src_out_q   <= src_out_d;
      etype_out_q <= etype_out_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      rdy_en_q    <= 1'b1;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      runt_cnt_q  <= runt_cnt_d;
    end
  end

  always_comb begin
    ch_tvalid_out = '0;
    ch_tlast_out  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (out_valid_q && (out_sel_q == 3'(i))) begin
        ch_tvalid_out[i] = 1'b1;
        ch_tlast_out[i]  = out_last_q;
      end
    end
  end

  assign ch_tdata_out  = {NUM_CH{out_data_q}};
  assign src_mac_out   = src_out_q;
  assign etype_out     = etype_out_q;
  assign ch_sel_out    = sel_q;
  assign frame_cnt_out = frame_cnt_q;
  assign drop_cnt_out  = drop_cnt_q;
  assign runt_cnt_out  = runt_cnt_q;
  assign dbg_state_o   = state_q;

endmodule
